// File: rtl/pipe_stage_skid_if.sv
// +----------------------------------------------------------------------------+
// | pipe_stage_skid_if : valid/ready/data handshake bundle for pipe_stage_skid |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int PAYLOAD_W = 133
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] data;

  // Producer side of a link: drives valid/data, observes ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Consumer side of a link: observes valid/data, drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// +----------------------------------------------------------------------------+
// | pipe_stage_skid : valid/ready pipeline latch with 2-entry skid buffer,     |
// | synchronous flush to a NOP bubble. Optional stats: PIPE_STAGE_STATS_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_skid #(
  parameter int                   PAYLOAD_W   = 133,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}}
) (
  input  wire                   clock,
  input  wire                   clear,
  input  wire                   flush,
  pipe_stage_skid_if.slave      i_up,
  pipe_stage_skid_if.master     o_dn
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [PAYLOAD_W-1:0]   r_main;
  logic [PAYLOAD_W-1:0]   r_skid;
  logic [PAYLOAD_W-1:0]   w_main_nx;
  logic [PAYLOAD_W-1:0]   w_skid_nx;
  logic                   r_in_ready;
  logic                   w_out_valid;
  logic                   w_in_fire;
  logic                   w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = i_up.valid & r_in_ready;
  assign w_out_fire  = w_out_valid & o_dn.ready;

  assign i_up.ready  = r_in_ready;
  assign o_dn.valid  = w_out_valid;
  assign o_dn.data   = w_out_valid ? r_main : NOP_PAYLOAD;

  always_comb begin
    w_state_nx = r_state;
    w_main_nx  = r_main;
    w_skid_nx  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_nx  = i_up.data;
          w_state_nx = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nx  = i_up.data;
        end else if (w_in_fire) begin
          w_skid_nx  = i_up.data;
          w_state_nx = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_nx  = r_skid;
          w_state_nx = ST_ONE;
        end
      end
      default: begin
        w_state_nx = ST_EMPTY;
      end
    endcase
    // Squash wins over any transfer in the same cycle; accepted input is dropped.
    if (flush) begin
      w_state_nx = ST_EMPTY;
      w_main_nx  = NOP_PAYLOAD;
      w_skid_nx  = NOP_PAYLOAD;
    end
  end

  // in_ready is registered from next state so no combinational ready path exists.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state    <= ST_EMPTY;
      r_main     <= NOP_PAYLOAD;
      r_skid     <= NOP_PAYLOAD;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_main     <= w_main_nx;
      r_skid     <= w_skid_nx;
      r_in_ready <= (w_state_nx != ST_FULL);
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic [1:0]  w_bubble_inc;
  logic [32:0] w_bubble_sum;

  // An empty cycle and a flush in the same cycle count as two bubbles.
  assign w_bubble_inc = {1'b0, ~w_out_valid} + {1'b0, flush};
  assign w_bubble_sum = {1'b0, r_bubble_cnt} + {31'd0, w_bubble_inc};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (w_out_valid && !o_dn.ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_bubble_sum[32]) begin
        r_bubble_cnt <= 32'hFFFF_FFFF;
      end else begin
        r_bubble_cnt <= w_bubble_sum[31:0];
      end
    end
  end

  assign stall_cycles  = r_stall_cnt;
  assign bubble_cycles = r_bubble_cnt;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (PAYLOAD_W=32, NOP=0).
`default_nettype none

module tb_pipe_stage_skid;

  logic clock;
  logic clear;
  logic flush;
  int   n_checks;
  int   n_fail;

  pipe_stage_skid_if #(.PAYLOAD_W(32)) up_if ();
  pipe_stage_skid_if #(.PAYLOAD_W(32)) dn_if ();

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
  logic [31:0] s0;
  logic [31:0] b1;
`endif

  pipe_stage_skid #(
    .PAYLOAD_W   (32),
    .NOP_PAYLOAD (32'h0)
  ) u_dut (
    .clock         (clock),
    .clear         (clear),
    .flush         (flush),
    .i_up          (up_if),
    .o_dn          (dn_if)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear    = 1'b1;
    flush    = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    // Reset asserted mid-cycle, checked before any clock edge.
    #3 clear = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, dn_if.valid}, 32'd0);
    chk("rst_out_data",  dn_if.data,           32'h0);
    chk("rst_in_ready",  {31'd0, up_if.ready}, 32'd1);
    #8 clear = 1'b1;
    step();

    // Streaming at full throughput.
    drive(1'b1, 32'h11, 1'b1); step();
    chk("str_d0", dn_if.data, 32'h11);
    chk("str_rdy0", {31'd0, up_if.ready}, 32'd1);
    drive(1'b1, 32'h22, 1'b1); step();
    chk("str_d1", dn_if.data, 32'h22);
    drive(1'b1, 32'h33, 1'b1); step();
    chk("str_d2", dn_if.data, 32'h33);
    chk("str_rdy2", {31'd0, up_if.ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b1); step();
    chk("str_empty", {31'd0, dn_if.valid}, 32'd0);

    // Stall into the skid register, then drain.
    drive(1'b1, 32'hA1, 1'b0); step();
    chk("sk_one", dn_if.data, 32'hA1);
    drive(1'b1, 32'hA2, 1'b0); step();
    chk("sk_full_rdy", {31'd0, up_if.ready}, 32'd0);
    chk("sk_full_d", dn_if.data, 32'hA1);
    drive(1'b0, 32'h0, 1'b1); step();
    chk("sk_drain_d", dn_if.data, 32'hA2);
    chk("sk_drain_rdy", {31'd0, up_if.ready}, 32'd1);
    step();
    chk("sk_empty", {31'd0, dn_if.valid}, 32'd0);

    // Flush while FULL with input offered.
    drive(1'b1, 32'hB1, 1'b0); step();
    drive(1'b1, 32'hB2, 1'b0); step();
    chk("fl_full", {31'd0, up_if.ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'hB3, 1'b0); step();
    flush = 1'b0;
    chk("fl_valid", {31'd0, dn_if.valid}, 32'd0);
    chk("fl_data", dn_if.data, 32'h0);
    chk("fl_rdy", {31'd0, up_if.ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b1); step();
    chk("fl_no_b3", {31'd0, dn_if.valid}, 32'd0);

    // Flush in ONE with an accepted input: the input is discarded.
    drive(1'b1, 32'hB4, 1'b0); step();
    chk("fl1_one", dn_if.data, 32'hB4);
    flush = 1'b1;
    drive(1'b1, 32'hB5, 1'b1); step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    chk("fl1_valid", {31'd0, dn_if.valid}, 32'd0);
    step();
    chk("fl1_no_b5", {31'd0, dn_if.valid}, 32'd0);

    // Asynchronous reset while FULL.
    drive(1'b1, 32'hC1, 1'b0); step();
    drive(1'b1, 32'hC2, 1'b0); step();
    drive(1'b0, 32'h0, 1'b0);
    #2 clear = 1'b0;
    #1;
    chk("mr_valid", {31'd0, dn_if.valid}, 32'd0);
    chk("mr_data", dn_if.data, 32'h0);
    chk("mr_rdy", {31'd0, up_if.ready}, 32'd1);
    #1 clear = 1'b1;
    drive(1'b1, 32'hC0, 1'b1); step();
    chk("mr_first", dn_if.data, 32'hC0);
    drive(1'b0, 32'h0, 1'b1); step();
    chk("mr_empty", {31'd0, dn_if.valid}, 32'd0);

`ifdef PIPE_STAGE_STATS_EN
    drive(1'b1, 32'hD1, 1'b0); step();
    s0 = stall_cycles;
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("st_stall", stall_cycles - s0, 32'd5);
    dn_if.ready = 1'b1; step();
    b1 = bubble_cycles;
    for (int i = 0; i < 3; i++) step();
    chk("st_bubble", bubble_cycles - b1, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
